// File: rtl/hazard_stall.sv
// hazard_stall: stall/bubble controller for the 5-stage MIPS pipeline.
//
// Sits beside the forwarding unit. It detects every dependency that the
// bypass muxes cannot cover and then holds PC and IF/ID while a bubble is
// pushed into ID/EX. It also owns the busy counter of the multi-cycle
// mult/div unit.
//
// Detected hazards:
//   - load-use: an EX-stage load feeds an operand that the ID instruction
//     needs in EX.
//   - ID-stage compares (beq/bne/jr/jalr) that need a result not yet
//     bypassable: any GPR writer in EX, or a load in MEM.
//   - HI/LO or mult/div traffic while the MD unit is busy or starting.
//
// Optional build macro HAZARD_PERF_EN adds the saturating performance
// counters stall_cnt and md_stall_cnt. When the macro is not defined,
// those ports and registers do not exist.
module hazard_stall #(
  parameter int unsigned MULT_CYCLES = 5,   // busy cycles after mult/multu start (1..15)
  parameter int unsigned DIV_CYCLES  = 10   // busy cycles after div/divu start (1..15)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rs_if_id,
  input  logic [4:0]  rt_if_id,
  input  logic        use_rs_ex,
  input  logic        use_rt_ex,
  input  logic        Branch,
  input  logic        jr,
  input  logic        jalr,
  input  logic        md_op_id,
  input  logic        RegWrite_id_ex,
  input  logic        MemRead_id_ex,
  input  logic [4:0]  WReg_id_ex,
  input  logic        RegWrite_ex_mem,
  input  logic        MemRead_ex_mem,
  input  logic [4:0]  WReg_ex_mem,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        exc_flush,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt,
`endif
  output logic        stall,
  output logic        bubble,
  output logic        md_busy,
  output logic [3:0]  md_count
);

  // Counter reload values. Both are trimmed to the 4-bit counter width.
  localparam logic [3:0] MULT_LOAD = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_LOAD  = DIV_CYCLES[3:0];

  // Two states of the MD unit. BUSY always means the count is non-zero.
  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True when a source register matches a destination. Register $0 never
  // counts, because writes to $0 are discarded and create no dependency.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src == dst) && (dst != 5'd0);
  endfunction

  // Combinational hazard terms
  logic      h_load_s;
  logic      h_br_ex_s;
  logic      h_br_mem_s;
  logic      h_md_s;
  logic      id_cmp_rs_s;
  logic      stall_s;

  // MD counter state
  md_state_e md_state_q, md_state_d;
  logic [3:0] md_count_q, md_count_d;
  logic      md_busy_s;

  // The MD unit is busy exactly while the counter is non-zero.
  assign md_busy_s = (md_count_q != 4'd0);

  // Hazard detection. A flush this cycle overrides every hazard, because
  // the flush logic owns the pipeline for that cycle.
  always_comb begin
    id_cmp_rs_s = Branch | jr | jalr;

    h_load_s = MemRead_id_ex & RegWrite_id_ex &
               ((use_rs_ex & reg_hit(rs_if_id, WReg_id_ex)) |
                (use_rt_ex & reg_hit(rt_if_id, WReg_id_ex)));

    h_br_ex_s = RegWrite_id_ex &
                ((id_cmp_rs_s & reg_hit(rs_if_id, WReg_id_ex)) |
                 (Branch      & reg_hit(rt_if_id, WReg_id_ex)));

    h_br_mem_s = MemRead_ex_mem & RegWrite_ex_mem &
                 ((id_cmp_rs_s & reg_hit(rs_if_id, WReg_ex_mem)) |
                  (Branch      & reg_hit(rt_if_id, WReg_ex_mem)));

    h_md_s = md_op_id & (md_busy_s | md_start);

    if (exc_flush) begin
      stall_s = 1'b0;
    end else begin
      stall_s = h_load_s | h_br_ex_s | h_br_mem_s | h_md_s;
    end
  end

  // MD counter next state. A start always reloads the counter. This also
  // covers a start while the unit is busy, where the counter restarts.
  // A flush does not affect the counter, so an in-flight op completes.
  always_comb begin
    md_state_d = md_state_q;
    md_count_d = md_count_q;
    case (md_state_q)
      MD_IDLE: begin
        if (md_start) begin
          md_count_d = md_is_div ? DIV_LOAD : MULT_LOAD;
          md_state_d = MD_BUSY;
        end else begin
          md_count_d = 4'd0;
          md_state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (md_start) begin
          md_count_d = md_is_div ? DIV_LOAD : MULT_LOAD;
          md_state_d = MD_BUSY;
        end else if (md_count_q > 4'd1) begin
          md_count_d = md_count_q - 4'd1;
          md_state_d = MD_BUSY;
        end else begin
          // Last busy cycle, or a defensive recovery from a zero count.
          md_count_d = 4'd0;
          md_state_d = MD_IDLE;
        end
      end
      default: begin
        md_count_d = 4'd0;
        md_state_d = MD_IDLE;
      end
    endcase
  end

  // MD state and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_state_q <= MD_IDLE;
      md_count_q <= 4'd0;
    end else begin
      md_state_q <= md_state_d;
      md_count_q <= md_count_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  // Saturating performance counters for all stall cycles and for MD stall cycles
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    md_stall_cnt_d = md_stall_cnt_q;
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (stall_s && h_md_s && (md_stall_cnt_q != 32'hFFFF_FFFF)) begin
      md_stall_cnt_d = md_stall_cnt_q + 32'd1;
    end else begin
      md_stall_cnt_d = md_stall_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q    <= 32'd0;
      md_stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

  assign stall    = stall_s;
  assign bubble   = stall_s;
  assign md_busy  = md_busy_s;
  assign md_count = md_count_q;

endmodule

// File: tb/tb_hazard_stall.sv
// Directed, scoreboard-based testbench for hazard_stall.
// Expected results are queued when stimulus is driven and popped and
// compared at the following falling clock edge.
module tb_hazard_stall;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rs_if_id, rt_if_id;
  logic        use_rs_ex, use_rt_ex, Branch, jr, jalr, md_op_id;
  logic        RegWrite_id_ex, MemRead_id_ex;
  logic [4:0]  WReg_id_ex;
  logic        RegWrite_ex_mem, MemRead_ex_mem;
  logic [4:0]  WReg_ex_mem;
  logic        md_start, md_is_div, exc_flush;
  logic        stall, bubble, md_busy;
  logic [3:0]  md_count;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, md_stall_cnt;
  int unsigned exp_stall_cnt;
  int unsigned exp_md_stall_cnt;
`endif

  int n_checks;
  int n_fail;

  typedef struct {
    string      tag;
    logic       st;
    logic [3:0] cnt;
    logic       md_hit;
  } exp_t;

  exp_t sb_q[$];

  hazard_stall #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rs_if_id        (rs_if_id),
    .rt_if_id        (rt_if_id),
    .use_rs_ex       (use_rs_ex),
    .use_rt_ex       (use_rt_ex),
    .Branch          (Branch),
    .jr              (jr),
    .jalr            (jalr),
    .md_op_id        (md_op_id),
    .RegWrite_id_ex  (RegWrite_id_ex),
    .MemRead_id_ex   (MemRead_id_ex),
    .WReg_id_ex      (WReg_id_ex),
    .RegWrite_ex_mem (RegWrite_ex_mem),
    .MemRead_ex_mem  (MemRead_ex_mem),
    .WReg_ex_mem     (WReg_ex_mem),
    .md_start        (md_start),
    .md_is_div       (md_is_div),
    .exc_flush       (exc_flush),
`ifdef HAZARD_PERF_EN
    .stall_cnt       (stall_cnt),
    .md_stall_cnt    (md_stall_cnt),
`endif
    .stall           (stall),
    .bubble          (bubble),
    .md_busy         (md_busy),
    .md_count        (md_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic clr_inputs();
    rs_if_id = 5'd0; rt_if_id = 5'd0;
    use_rs_ex = 1'b0; use_rt_ex = 1'b0;
    Branch = 1'b0; jr = 1'b0; jalr = 1'b0; md_op_id = 1'b0;
    RegWrite_id_ex = 1'b0; MemRead_id_ex = 1'b0; WReg_id_ex = 5'd0;
    RegWrite_ex_mem = 1'b0; MemRead_ex_mem = 1'b0; WReg_ex_mem = 5'd0;
    md_start = 1'b0; md_is_div = 1'b0; exc_flush = 1'b0;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pops one expectation and compares it with the outputs at this moment.
  task automatic pop_check();
    exp_t e;
    e = sb_q.pop_front();
    check_bit({e.tag, ".stall"},  stall,    e.st);
    check_bit({e.tag, ".bubble"}, bubble,   e.st);
    check_bit({e.tag, ".busy"},   md_busy,  (e.cnt != 4'd0));
    check_cnt({e.tag, ".count"},  md_count, e.cnt);
`ifdef HAZARD_PERF_EN
    n_checks++;
    assert (stall_cnt === exp_stall_cnt) else begin
      n_fail++;
      $error("FAIL %s.stall_cnt: observed %0d expected %0d", e.tag, stall_cnt, exp_stall_cnt);
    end
    n_checks++;
    assert (md_stall_cnt === exp_md_stall_cnt) else begin
      n_fail++;
      $error("FAIL %s.md_stall_cnt: observed %0d expected %0d", e.tag, md_stall_cnt, exp_md_stall_cnt);
    end
    // This step's inputs are counted at the coming rising edge.
    if (e.st) exp_stall_cnt++;
    if (e.st && e.md_hit) exp_md_stall_cnt++;
`endif
  endtask

  // Moves to the drive point of the next cycle: just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Queues the expected result for the current inputs. The check follows
  // at the falling edge.
  task automatic step(input string tag, input logic exp_st, input logic [3:0] exp_cnt);
    exp_t e;
    e.tag    = tag;
    e.st     = exp_st;
    e.cnt    = exp_cnt;
    e.md_hit = md_op_id && ((exp_cnt != 4'd0) || md_start);
    sb_q.push_back(e);
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef HAZARD_PERF_EN
    exp_stall_cnt    = 0;
    exp_md_stall_cnt = 0;
`endif
    clr_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    step("reset", 1'b0, 4'd0);
    #2 reset_n = 1'b1;

    next_cycle(); step("idle", 1'b0, 4'd0);

    // Load-use on rs: stalls for one cycle, then the bubble is in EX.
    next_cycle(); clr_inputs();
    MemRead_id_ex = 1'b1; RegWrite_id_ex = 1'b1; WReg_id_ex = 5'd5;
    use_rs_ex = 1'b1; rs_if_id = 5'd5; rt_if_id = 5'd6; use_rt_ex = 1'b1;
    step("lu_rs", 1'b1, 4'd0);
    next_cycle(); MemRead_id_ex = 1'b0; RegWrite_id_ex = 1'b0; WReg_id_ex = 5'd0;
    step("lu_after", 1'b0, 4'd0);

    // A load into $0 is never a dependency.
    next_cycle(); MemRead_id_ex = 1'b1; RegWrite_id_ex = 1'b1; WReg_id_ex = 5'd0; rs_if_id = 5'd0;
    step("lu_zero", 1'b0, 4'd0);

    // Load-use through rt (sw data), and an ALU producer that is forwardable.
    next_cycle(); clr_inputs();
    MemRead_id_ex = 1'b1; RegWrite_id_ex = 1'b1; WReg_id_ex = 5'd7;
    use_rt_ex = 1'b1; rt_if_id = 5'd7; rs_if_id = 5'd3; use_rs_ex = 1'b1;
    step("lu_rt", 1'b1, 4'd0);
    next_cycle(); MemRead_id_ex = 1'b0;
    step("alu_fwd", 1'b0, 4'd0);

    // beq $8,$9 after lw $9: two stall cycles (EX, then MEM).
    next_cycle(); clr_inputs();
    Branch = 1'b1; rs_if_id = 5'd8; rt_if_id = 5'd9;
    MemRead_id_ex = 1'b1; RegWrite_id_ex = 1'b1; WReg_id_ex = 5'd9;
    step("br_ld_ex", 1'b1, 4'd0);
    next_cycle(); MemRead_id_ex = 1'b0; RegWrite_id_ex = 1'b0; WReg_id_ex = 5'd0;
    MemRead_ex_mem = 1'b1; RegWrite_ex_mem = 1'b1; WReg_ex_mem = 5'd9;
    step("br_ld_mem", 1'b1, 4'd0);
    next_cycle(); MemRead_ex_mem = 1'b0; RegWrite_ex_mem = 1'b0; WReg_ex_mem = 5'd0;
    step("br_ld_done", 1'b0, 4'd0);

    // beq after ALU: one cycle; an ALU result in MEM is bypassable.
    next_cycle(); RegWrite_id_ex = 1'b1; WReg_id_ex = 5'd8;
    step("br_alu_ex", 1'b1, 4'd0);
    next_cycle(); RegWrite_id_ex = 1'b0; WReg_id_ex = 5'd0;
    RegWrite_ex_mem = 1'b1; WReg_ex_mem = 5'd8;
    step("br_alu_mem", 1'b0, 4'd0);

    // jr reads only rs, so a hit on rt does not stall it.
    next_cycle(); clr_inputs();
    jr = 1'b1; rs_if_id = 5'd4; rt_if_id = 5'd2;
    MemRead_ex_mem = 1'b1; RegWrite_ex_mem = 1'b1; WReg_ex_mem = 5'd4;
    step("jr_ld_mem", 1'b1, 4'd0);
    next_cycle(); clr_inputs();
    jr = 1'b1; rs_if_id = 5'd2; rt_if_id = 5'd4; RegWrite_id_ex = 1'b1; WReg_id_ex = 5'd4;
    step("jr_rt_nohit", 1'b0, 4'd0);
    next_cycle(); jr = 1'b0; jalr = 1'b1; rs_if_id = 5'd4;
    step("jalr_ex", 1'b1, 4'd0);

    // mult starts with an MD op in ID; mflo then stays stalled for 5 cycles.
    next_cycle(); clr_inputs();
    md_start = 1'b1; md_is_div = 1'b0; md_op_id = 1'b1;
    step("mult_start", 1'b1, 4'd0);
    next_cycle(); md_start = 1'b0;
    step("mflo_c5", 1'b1, 4'd5);
    for (int i = 4; i >= 1; i--) begin
      next_cycle();
      step("mflo_busy", 1'b1, 4'(i));
    end
    next_cycle(); step("mflo_release", 1'b0, 4'd0);

    // div start: 10 busy cycles. A load-use under flush does not stall and
    // does not disturb the counter.
    next_cycle(); clr_inputs();
    md_start = 1'b1; md_is_div = 1'b1;
    step("div_start", 1'b0, 4'd0);
    next_cycle(); clr_inputs();
    exc_flush = 1'b1; md_op_id = 1'b1;
    MemRead_id_ex = 1'b1; RegWrite_id_ex = 1'b1; WReg_id_ex = 5'd5;
    use_rs_ex = 1'b1; rs_if_id = 5'd5;
    step("flush_wins", 1'b0, 4'd10);
    next_cycle(); clr_inputs(); md_op_id = 1'b1;
    for (int i = 9; i >= 1; i--) begin
      step("div_busy", 1'b1, 4'(i));
      next_cycle();
    end
    step("div_release", 1'b0, 4'd0);

    // A restart while busy reloads the counter.
    next_cycle(); clr_inputs(); md_start = 1'b1;
    step("restart_a", 1'b0, 4'd0);
    next_cycle(); md_start = 1'b0;
    step("restart_b", 1'b0, 4'd5);
    next_cycle(); md_start = 1'b1; md_is_div = 1'b1;
    step("restart_c", 1'b0, 4'd4);
    next_cycle(); md_start = 1'b0; md_is_div = 1'b0;
    step("restart_d", 1'b0, 4'd10);
    for (int i = 9; i >= 7; i--) begin
      next_cycle();
      step("pre_reset", 1'b0, 4'(i));
    end

    // Asynchronous reset while md_count is 7, away from any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check_cnt("async_rst.count", md_count, 4'd0);
    check_bit("async_rst.busy", md_busy, 1'b0);
    check_bit("async_rst.stall", stall, 1'b0);
`ifdef HAZARD_PERF_EN
    exp_stall_cnt    = 0;
    exp_md_stall_cnt = 0;
    n_checks++;
    assert (stall_cnt === 32'd0 && md_stall_cnt === 32'd0) else begin
      n_fail++;
      $error("FAIL async_rst.perf: observed %0d/%0d expected 0/0", stall_cnt, md_stall_cnt);
    end
`endif
    // During reset the hazard logic still follows the inputs combinationally.
    Branch = 1'b1; rs_if_id = 5'd3; RegWrite_id_ex = 1'b1; WReg_id_ex = 5'd3;
    #1 check_bit("rst_comb.stall", stall, 1'b1);
    clr_inputs();
    @(posedge clk);
    #2 reset_n = 1'b1;
    next_cycle(); step("post_reset", 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall.md
Name: hazard_stall

Overview:
- Stall/bubble controller for the 5-stage MIPS pipeline; the counterpart of the forwarding unit.
- Flags every dependency that bypass muxes cannot resolve, and freezes PC and IF/ID while it lasts:
  - load-use hazards;
  - ID-stage branch/jr/jalr compares that need a result not yet bypassable;
  - mult/div/HI/LO accesses while the multi-cycle MD unit is busy.
- Owns the MD busy counter.
- Sits beside the forwarding unit in the control directory; drives PC enable, IF/ID enable and the ID/EX clear.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15).
- DIV_CYCLES, 10, busy cycles after a div/divu start (1..15).

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs_if_id  in  5  rs of the instruction in ID.
- rt_if_id  in  5  rt of the instruction in ID.
- use_rs_ex  in  1  ID instruction reads rs in EX.
- use_rt_ex  in  1  ID instruction reads rt in EX (includes sw data).
- Branch  in  1  ID instruction is beq/bne (reads rs and rt in ID).
- jr  in  1  ID instruction is jr (reads rs in ID).
- jalr  in  1  ID instruction is jalr (reads rs in ID).
- md_op_id  in  1  ID instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- RegWrite_id_ex  in  1  EX instruction writes the GPR file.
- MemRead_id_ex  in  1  EX instruction is a load.
- WReg_id_ex  in  5  destination of the EX instruction.
- RegWrite_ex_mem  in  1  MEM instruction writes the GPR file.
- MemRead_ex_mem  in  1  MEM instruction is a load.
- WReg_ex_mem  in  5  destination of the MEM instruction.
- md_start  in  1  mult/div is in EX this cycle.
- md_is_div  in  1  qualifies md_start: 1 = div/divu.
- exc_flush  in  1  CP0 exception/eret flush this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  clear ID/EX (insert nop).
- md_busy  out  1  MD unit computing.
- md_count  out  4  remaining MD busy cycles.

Behaviour:
- Combinational hazard terms. "rX hit Y" means rX==WReg_Y and WReg_Y!=0.
  - H_load = MemRead_id_ex and RegWrite_id_ex and ((use_rs_ex and rs hit id_ex) or (use_rt_ex and rt hit id_ex)).
  - H_br_ex = RegWrite_id_ex and (((Branch or jr or jalr) and rs hit id_ex) or (Branch and rt hit id_ex)).
  - H_br_mem = MemRead_ex_mem and RegWrite_ex_mem and (((Branch or jr or jalr) and rs hit ex_mem) or (Branch and rt hit ex_mem)).
  - H_md = md_op_id and (md_busy or md_start).
- Outputs:
  - stall = bubble = (H_load or H_br_ex or H_br_mem or H_md) and not exc_flush.
  - exc_flush wins over every hazard; the flush logic handles the pipeline that cycle.
- MD counter (4-bit register md_count):
  - States: IDLE (count==0) and BUSY (count!=0). md_busy = (count!=0).
  - md_start at edge T loads DIV_CYCLES if md_is_div, else MULT_CYCLES.
  - Otherwise, if count!=0, decrement by 1 per edge; no wrap below 0.
  - Mult started at edge T: md_busy high for exactly MULT_CYCLES cycles after T, then low.
  - md_start while BUSY (illegal under correct stalling): the reload wins; the counter restarts.
  - exc_flush does not touch the counter; an in-flight mult/div completes.
- Reset (asynchronous, any time, including mid-operation): md_count=0, md_busy=0. stall and bubble then follow the inputs combinationally (0 when all inputs are idle).
- Stall duration emerges from the pipeline: load-use stalls 1 cycle; branch after ALU stalls 1 cycle; branch after load stalls 2 cycles (H_br_ex, then H_br_mem).

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds outputs stall_cnt[31:0] and md_stall_cnt[31:0], both saturating at 32'hFFFFFFFF and cleared by reset_n.
  - stall_cnt increments each cycle stall=1.
  - md_stall_cnt increments each cycle stall=1 and H_md=1.
- Undefined: no such ports or registers; all other behaviour identical.

Test Plan:
- lw $5 in EX (MemRead_id_ex=1, WReg_id_ex=5), add $3,$5,$6 in ID (use_rs_ex=1, rs=5) -> stall=bubble=1 for one cycle. Repeat with WReg_id_ex=0 -> stall=0.
- beq $8,$9 in ID, lw $9 in EX -> stall=1; next cycle load moves to MEM (MemRead_ex_mem=1, WReg_ex_mem=9) -> stall=1; third cycle -> stall=0.
- md_start=1, md_is_div=0 at edge T -> md_count=5 after T, then 4,3,2,1,0; mflo in ID keeps stall=1 for exactly 5 cycles, released when md_count=0. With md_is_div=1 -> 10 cycles.
- md_start with a mult/div also in ID the same cycle -> stall=1 that cycle, and the ID instruction remains stalled while busy.
- Load-use hazard with exc_flush=1 -> stall=bubble=0; md_count keeps decrementing across the flush.
- reset_n pulled low while md_count=7 -> md_count=0 and md_busy=0 immediately (no clock edge needed); with HAZARD_PERF_EN, counters read 0.
